// File: rtl/sb_mem_slave_if.sv
// sb_mem_slave_if: system bus signal bundle seen by the memory slave.
interface sb_mem_slave_if;
    logic        sb_begin_transaction_i;
    logic        sb_end_transaction_i;
    logic        sb_data_valid_i;
    logic [31:0] sb_address_data_i;
    logic [3:0]  sb_byte_enables_i;
    logic [7:0]  sb_burst_size_i;
    logic        sb_read_n_write_i;
    logic        sb_error_i;
    logic [31:0] sb_address_data_o;
    logic        sb_data_valid_o;
    logic        sb_end_transaction_o;
    logic        sb_busy_o;
    logic        sb_error_o;

    modport slave (
        input  sb_begin_transaction_i, sb_end_transaction_i, sb_data_valid_i,
               sb_address_data_i, sb_byte_enables_i, sb_burst_size_i,
               sb_read_n_write_i, sb_error_i,
        output sb_address_data_o, sb_data_valid_o, sb_end_transaction_o,
               sb_busy_o, sb_error_o
    );

    modport master (
        output sb_begin_transaction_i, sb_end_transaction_i, sb_data_valid_i,
               sb_address_data_i, sb_byte_enables_i, sb_burst_size_i,
               sb_read_n_write_i, sb_error_i,
        input  sb_address_data_o, sb_data_valid_o, sb_end_transaction_o,
               sb_busy_o, sb_error_o
    );
endinterface

// File: rtl/sb_mem_slave.sv
// sb_mem_slave: on-chip word memory answering single/burst system bus transactions.
// Optional feature: define SB_MEM_SLAVE_WRAP_EN to wrap bursts that cross the top of
// the window modulo depth; without it such bursts end in a one-cycle error pulse.
module sb_mem_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_WAIT   = 0
) (
    input logic           sb_clock_i,
    input logic           sb_reset_n_i,
    sb_mem_slave_if.slave sb
);
    localparam int unsigned DEPTH     = 32'd1 << ADDR_BITS;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned LAT_W     = 4;
    localparam int unsigned WIN_SHIFT = ADDR_BITS + 2;
    localparam logic [LAT_W-1:0] RD_WAIT_INIT =
        LAT_W'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);
    localparam logic [LAT_W-1:0] WR_WAIT_INIT = LAT_W'(WRITE_WAIT);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] RD_END  = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] ERR     = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d, addr_idx, rd_idx;
    logic [CNT_W-1:0]     cnt_q, cnt_d, burst_beats;
    logic [LAT_W-1:0]     wait_q, wait_d;
    logic [31:0]          rdata_q, rdata_d, offset, rd_word;
    logic                 valid_q, valid_d, end_q, end_d;
    logic                 busy_q, busy_d, err_q, err_d;
    logic                 in_window, top_cross, wr_beat, abort_rd, mem_we;
    logic [31:0]          mem [DEPTH];

    // Address decode against the window; bits [1:0] fall away with the word index.
    assign offset      = sb.sb_address_data_i - BASE_ADDR;
    assign in_window   = (offset >> WIN_SHIFT) == 32'd0;
    assign addr_idx    = offset[ADDR_BITS+1:2];
    assign burst_beats = CNT_W'(sb.sb_burst_size_i) + CNT_W'(1);

`ifdef SB_MEM_SLAVE_WRAP_EN
    assign top_cross = 1'b0;
`else
    assign top_cross = (32'(addr_idx) + 32'(sb.sb_burst_size_i)) >= 32'(DEPTH);
`endif

    // Single read port: the decoded index while idle (latency 1), else the burst pointer.
    assign rd_idx   = (state_q == IDLE) ? addr_idx : idx_q;
    assign rd_word  = mem[rd_idx];
    assign wr_beat  = sb.sb_data_valid_i & ~busy_q;
    assign abort_rd = sb.sb_error_i | sb.sb_end_transaction_i;

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        rdata_d = '0;
        valid_d = 1'b0;
        end_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sb.sb_begin_transaction_i && in_window) begin
                    if (top_cross) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (sb.sb_read_n_write_i) begin
                        if (READ_LATENCY <= 1) begin
                            state_d = RD_DATA;
                            valid_d = 1'b1;
                            rdata_d = rd_word;
                            idx_d   = addr_idx + ADDR_BITS'(1);
                            cnt_d   = CNT_W'(sb.sb_burst_size_i);
                        end else begin
                            state_d = RD_WAIT;
                            idx_d   = addr_idx;
                            cnt_d   = burst_beats;
                            wait_d  = RD_WAIT_INIT;
                        end
                    end else begin
                        state_d = WR_DATA;
                        idx_d   = addr_idx;
                        cnt_d   = burst_beats;
                        wait_d  = WR_WAIT_INIT;
                        busy_d  = (WR_WAIT_INIT != '0);
                    end
                end
            end
            RD_WAIT: begin
                if (abort_rd) begin
                    state_d = IDLE;
                end else if (wait_q == '0) begin
                    state_d = RD_DATA;
                    valid_d = 1'b1;
                    rdata_d = rd_word;
                    idx_d   = idx_q + ADDR_BITS'(1);
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            RD_DATA: begin
                if (abort_rd) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RD_END;
                    end_d   = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    rdata_d = rd_word;
                    idx_d   = idx_q + ADDR_BITS'(1);
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            RD_END: begin
                state_d = IDLE;
            end
            WR_DATA: begin
                if (sb.sb_error_i) begin
                    state_d = IDLE;
                end else if (wr_beat && (cnt_q == '0)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    if (wr_beat) begin
                        mem_we = 1'b1;
                        idx_d  = idx_q + ADDR_BITS'(1);
                        cnt_d  = cnt_q - CNT_W'(1);
                    end
                    if (sb.sb_end_transaction_i) begin
                        state_d = IDLE;
                    end else if (wait_q != '0) begin
                        wait_d = wait_q - LAT_W'(1);
                        busy_d = (wait_q != LAT_W'(1));
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst bookkeeping and registered bus outputs.
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Byte-enabled write port; contents survive reset.
    always_ff @(posedge sb_clock_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sb.sb_byte_enables_i[b]) begin
                    mem[idx_q][8*b +: 8] <= sb.sb_address_data_i[8*b +: 8];
                end
            end
        end
    end

    assign sb.sb_address_data_o    = rdata_q;
    assign sb.sb_data_valid_o      = valid_q;
    assign sb.sb_end_transaction_o = end_q;
    assign sb.sb_busy_o            = busy_q;
    assign sb.sb_error_o           = err_q;
endmodule

// File: tb/tb_sb_mem_slave.sv
// tb_sb_mem_slave: directed bench with a cycle-schedule model of the memory slave.
module tb_sb_mem_slave;
    localparam int          AB    = 12;
    localparam int          DEPTH = 1 << AB;
    localparam int          RL    = 2;
    localparam int          WW    = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          NC    = 4096;
`ifdef SB_MEM_SLAVE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } beat_t;

    logic sb_clock_i;
    logic sb_reset_n_i;
    sb_mem_slave_if bus ();

    sb_mem_slave #(
        .BASE_ADDR   (BASE),
        .ADDR_BITS   (AB),
        .READ_LATENCY(RL),
        .WRITE_WAIT  (WW)
    ) dut (
        .sb_clock_i  (sb_clock_i),
        .sb_reset_n_i(sb_reset_n_i),
        .sb(bus.slave)
    );

    // Expected outputs per cycle; unscheduled cycles expect all zeros.
    bit          exp_valid [NC];
    bit          exp_end   [NC];
    bit          exp_busy  [NC];
    bit          exp_err   [NC];
    logic [31:0] exp_data  [NC];
    logic [31:0] model_mem [DEPTH];

    beat_t       obs[$];
    int          end_q[$];
    int          err_q[$];
    int          busy_q[$];
    logic [31:0] wq[$];
    int          cyc;
    int          n_cmp;
    int          n_fail;

    initial begin
        sb_clock_i = 1'b0;
        forever #5 sb_clock_i = ~sb_clock_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the schedule; also logs activity.
    task automatic cycle_check();
        chk("data_valid_o", 32'(bus.sb_data_valid_o), 32'(exp_valid[cyc]));
        chk("address_data_o", bus.sb_address_data_o, exp_data[cyc]);
        chk("end_transaction_o", 32'(bus.sb_end_transaction_o), 32'(exp_end[cyc]));
        chk("busy_o", 32'(bus.sb_busy_o), 32'(exp_busy[cyc]));
        chk("error_o", 32'(bus.sb_error_o), 32'(exp_err[cyc]));
        if (bus.sb_data_valid_o === 1'b1) obs.push_back('{cyc, bus.sb_address_data_o});
        if (bus.sb_end_transaction_o === 1'b1) end_q.push_back(cyc);
        if (bus.sb_error_o === 1'b1) err_q.push_back(cyc);
        if (bus.sb_busy_o === 1'b1) busy_q.push_back(cyc);
    endtask

    task automatic tick();
        @(negedge sb_clock_i);
        cycle_check();
        @(posedge sb_clock_i);
        cyc++;
        #1;
        if (cyc >= NC - 64) begin
            $display("FAIL cycle_budget: cycle %0d exceeds schedule", cyc);
            $fatal(1, "cycle budget");
        end
    endtask

    function automatic void decode(input logic [31:0] addr, output bit inwin, output int idx);
        longint off;
        off   = longint'(addr) - longint'(BASE);
        inwin = (off >= 0) && (off < 4 * longint'(DEPTH));
        idx   = int'(off / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] obs_data(input int i);
        if (i < obs.size()) return obs[i].data;
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int obs_cyc(input int i);
        if (i < obs.size()) return obs[i].cyc;
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Write burst with the beats in wq; master holds the first beat through busy.
    task automatic do_write(input logic [31:0] addr, input int bs, input logic [3:0] be,
                            output int t0);
        bit inwin;
        int idx;
        bit ok;
        int nb;
        nb = wq.size();
        t0 = cyc;
        decode(addr, inwin, idx);
        ok = inwin && (WRAP || (idx + bs < DEPTH));
        if (inwin && !ok) exp_err[t0+1] = 1'b1;
        if (ok) for (int c = t0 + 1; c <= t0 + WW; c++) exp_busy[c] = 1'b1;
        bus.sb_begin_transaction_i = 1'b1;
        bus.sb_address_data_i      = addr;
        bus.sb_burst_size_i        = 8'(bs);
        bus.sb_read_n_write_i      = 1'b0;
        bus.sb_byte_enables_i      = be;
        tick();
        bus.sb_begin_transaction_i = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.sb_data_valid_i   = 1'b1;
            bus.sb_address_data_i = wq[i];
            if (i == 0) repeat (WW) tick();
            if (ok && i > bs) begin
                exp_err[cyc+1] = 1'b1;
                tick();
                break;
            end
            if (ok) model_mem[(idx+i)%DEPTH] = merge(model_mem[(idx+i)%DEPTH], wq[i], be);
            tick();
        end
        bus.sb_data_valid_i      = 1'b0;
        bus.sb_address_data_i    = '0;
        bus.sb_end_transaction_i = 1'b1;
        tick();
        bus.sb_end_transaction_i = 1'b0;
        tick();
    endtask

    // Read burst; kind 0 = none, 1 = error_i, 2 = end_i, 3 = reset, applied in cycle t0+at.
    task automatic do_read(input logic [31:0] addr, input int bs, input int kind,
                           input int at, output int t0);
        bit inwin;
        int idx;
        int lim;
        int total;
        t0 = cyc;
        decode(addr, inwin, idx);
        lim = (kind == 0) ? NC : ((kind == 3) ? t0 + at - 1 : t0 + at);
        if (inwin) begin
            if (!WRAP && (idx + bs >= DEPTH)) begin
                exp_err[t0+1] = 1'b1;
            end else begin
                for (int k = 0; k <= bs; k++) begin
                    if (t0 + RL + k <= lim) begin
                        exp_valid[t0+RL+k] = 1'b1;
                        exp_data[t0+RL+k]  = model_mem[(idx+k)%DEPTH];
                    end
                end
                if (t0 + RL + bs + 1 <= lim) exp_end[t0+RL+bs+1] = 1'b1;
            end
        end
        bus.sb_begin_transaction_i = 1'b1;
        bus.sb_address_data_i      = addr;
        bus.sb_burst_size_i        = 8'(bs);
        bus.sb_read_n_write_i      = 1'b1;
        tick();
        bus.sb_begin_transaction_i = 1'b0;
        bus.sb_address_data_i      = '0;
        total = RL + bs + 2;
        for (int r = 1; r <= total; r++) begin
            if (r == at && kind == 1) bus.sb_error_i = 1'b1;
            if (r == at && kind == 2) bus.sb_end_transaction_i = 1'b1;
            if (r == at && kind == 3) begin
                #2;
                sb_reset_n_i = 1'b0;
                #1;
                chk("rst_address_data", bus.sb_address_data_o, 32'h0);
                chk("rst_data_valid", 32'(bus.sb_data_valid_o), 32'h0);
                chk("rst_end", 32'(bus.sb_end_transaction_o), 32'h0);
                chk("rst_busy", 32'(bus.sb_busy_o), 32'h0);
                chk("rst_error", 32'(bus.sb_error_o), 32'h0);
            end
            tick();
            bus.sb_error_i           = 1'b0;
            bus.sb_end_transaction_i = 1'b0;
            sb_reset_n_i             = 1'b1;
        end
    endtask

    initial begin
        int t;
        int b;
        int e;
        int er;
        int bq;
        for (int i = 0; i < NC; i++) exp_data[i] = '0;
        cyc    = 0;
        n_cmp  = 0;
        n_fail = 0;
        bus.sb_begin_transaction_i = 1'b0;
        bus.sb_end_transaction_i   = 1'b0;
        bus.sb_data_valid_i        = 1'b0;
        bus.sb_address_data_i      = '0;
        bus.sb_byte_enables_i      = 4'hF;
        bus.sb_burst_size_i        = '0;
        bus.sb_read_n_write_i      = 1'b0;
        bus.sb_error_i             = 1'b0;
        sb_reset_n_i = 1'b1;
        #1;
        sb_reset_n_i = 1'b0;
        repeat (3) tick();
        chk("reset_address_data", bus.sb_address_data_o, 32'h0);
        chk("reset_data_valid", 32'(bus.sb_data_valid_o), 32'h0);
        chk("reset_end", 32'(bus.sb_end_transaction_o), 32'h0);
        chk("reset_busy", 32'(bus.sb_busy_o), 32'h0);
        chk("reset_error", 32'(bus.sb_error_o), 32'h0);
        sb_reset_n_i = 1'b1;
        tick();

        // Single write then single read.
        wq = '{32'hDEAD_BEEF};
        do_write(32'h0000_1000, 0, 4'hF, t);
        b = obs.size();
        e = end_q.size();
        do_read(32'h0000_1000, 0, 0, 0, t);
        chk("single_beats", 32'(obs.size() - b), 32'd1);
        chk("single_data", obs_data(b), 32'hDEAD_BEEF);
        chk("single_beat_cycle", 32'(obs_cyc(b) - t), 32'd2);
        chk("single_end_cycle", 32'(q_at(end_q, e) - t), 32'd3);

        // Byte-enable merge.
        wq = '{32'h1122_3344};
        do_write(32'h0000_1000, 0, 4'b0101, t);
        b = obs.size();
        do_read(32'h0000_1000, 0, 0, 0, t);
        chk("byte_enable_data", obs_data(b), 32'hDE22_BE44);

        // Burst write under back-pressure, then burst read.
        bq = busy_q.size();
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(32'h0000_0000, 3, 4'hF, t);
        chk("busy_cycles", 32'(busy_q.size() - bq), 32'd3);
        chk("busy_first_cycle", 32'(q_at(busy_q, bq) - t), 32'd1);
        b = obs.size();
        e = end_q.size();
        do_read(32'h0000_0000, 3, 0, 0, t);
        chk("burst_beats", 32'(obs.size() - b), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("burst_data", obs_data(b + k), 32'(k + 1));
            chk("burst_beat_cycle", 32'(obs_cyc(b + k) - t), 32'(2 + k));
        end
        chk("burst_end_cycle", 32'(q_at(end_q, e) - t), 32'd6);

        // Window miss: nothing for 20 cycles, then a normal read is serviced.
        b  = obs.size();
        er = err_q.size();
        e  = end_q.size();
        do_read(32'h8000_0000, 0, 0, 0, t);
        repeat (16) tick();
        chk("miss_beats", 32'(obs.size() - b), 32'd0);
        chk("miss_errors", 32'(err_q.size() - er), 32'd0);
        chk("miss_ends", 32'(end_q.size() - e), 32'd0);
        b = obs.size();
        do_read(32'h0000_0000, 0, 0, 0, t);
        chk("after_miss_data", obs_data(b), 32'd1);

        // Top crossing read.
        wq = '{32'hA0A0_0001, 32'hB0B0_0002};
        do_write(32'h0000_3FF8, 1, 4'hF, t);
        b  = obs.size();
        er = err_q.size();
        do_read(32'h0000_3FF8, 3, 0, 0, t);
        if (WRAP) begin
            chk("wrap_beats", 32'(obs.size() - b), 32'd4);
            chk("wrap_data0", obs_data(b), 32'hA0A0_0001);
            chk("wrap_data1", obs_data(b + 1), 32'hB0B0_0002);
            chk("wrap_data2", obs_data(b + 2), 32'd1);
            chk("wrap_data3", obs_data(b + 3), 32'd2);
        end else begin
            chk("cross_beats", 32'(obs.size() - b), 32'd0);
            chk("cross_errors", 32'(err_q.size() - er), 32'd1);
            chk("cross_error_cycle", 32'(q_at(err_q, er) - t), 32'd1);
        end

        // Top crossing write.
        er = err_q.size();
        wq = '{32'h5555_5555, 32'h6666_6666};
        do_write(32'h0000_3FFC, 1, 4'hF, t);
        chk("cross_wr_errors", 32'(err_q.size() - er), WRAP ? 32'd0 : 32'd1);
        b = obs.size();
        do_read(32'h0000_3FFC, 0, 0, 0, t);
        chk("cross_wr_data", obs_data(b), WRAP ? 32'h5555_5555 : 32'hB0B0_0002);

        // Extra write beat past the announced count.
        er = err_q.size();
        wq = '{32'h0000_0077, 32'h0000_0088};
        do_write(32'h0000_0100, 0, 4'hF, t);
        chk("overrun_errors", 32'(err_q.size() - er), 32'd1);
        chk("overrun_error_cycle", 32'(q_at(err_q, er) - t), 32'(WW + 3));
        b = obs.size();
        do_read(32'h0000_0100, 0, 0, 0, t);
        chk("overrun_data", obs_data(b), 32'h0000_0077);

        // Read aborts by error_i and by end_i.
        b = obs.size();
        do_read(32'h0000_0000, 3, 1, 3, t);
        chk("abort_err_beats", 32'(obs.size() - b), 32'd2);
        b = obs.size();
        e = end_q.size();
        do_read(32'h0000_0000, 3, 2, 2, t);
        chk("abort_end_beats", 32'(obs.size() - b), 32'd1);
        chk("abort_end_ends", 32'(end_q.size() - e), 32'd0);

        // Reset mid-burst, then a normal transaction.
        b = obs.size();
        do_read(32'h0000_0000, 3, 3, 3, t);
        chk("reset_mid_beats", 32'(obs.size() - b), 32'd1);
        b = obs.size();
        do_read(32'h0000_1000, 0, 0, 0, t);
        chk("after_reset_data", obs_data(b), 32'hDE22_BE44);
        chk("after_reset_cycle", 32'(obs_cyc(b) - t), 32'd2);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_mem_slave.md
# sb_mem_slave

Synthesizable, parametrised on-chip memory slave for the shared system bus. It answers single and burst read/write transactions from any bus master (for example the JTAG debug bus master) inside a configurable address window. It also provides configurable read latency, write back-pressure via busy, byte-enable writes, and error signalling. It supersedes the ad-hoc behavioural slave used in debug-interface benches and can be instantiated both in the SoC and in benches.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4·2^ADDR_BITS.
- ADDR_BITS, 10, log2 of depth in 32-bit words (depth = 2^ADDR_BITS).
- READ_LATENCY, 2, cycles from begin-transaction sample to first read beat; legal range 1..15.
- WRITE_WAIT, 0, busy cycles inserted before the first write beat is accepted; legal range 0..15.

Ports:
- sb_clock_i  in  1  system bus clock; all logic on the rising edge.
- sb_reset_n_i  in  1  asynchronous, active-low reset.
- sb_begin_transaction_i  in  1  address phase strobe.
- sb_end_transaction_i  in  1  end of transaction (master write end, or any agent).
- sb_data_valid_i  in  1  write beat valid.
- sb_address_data_i  in  32  address in the address phase, write data in data beats.
- sb_byte_enables_i  in  4  per-byte write enables; bit n enables bits [8n+7:8n].
- sb_burst_size_i  in  8  beats minus 1; sampled with begin.
- sb_read_n_write_i  in  1  1 = read, 0 = write; sampled with begin.
- sb_error_i  in  1  bus error from any agent, including the arbiter.
- sb_address_data_o  out  32  read data; 0 whenever sb_data_valid_o = 0 (wired-OR bus).
- sb_data_valid_o  out  1  read beat valid.
- sb_end_transaction_o  out  1  one-cycle end of a read transaction.
- sb_busy_o  out  1  write back-pressure.
- sb_error_o  out  1  one-cycle error pulse.

## Operation
- FSM states: IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR.
- IDLE: on sb_begin_transaction_i, decode word index idx = (addr − BASE_ADDR) >> 2.
  - Address bits [1:0] are ignored.
  - Address outside the window: not selected; remain in IDLE with no output activity.
  - In window: latch idx, beat count = burst_size + 1, and direction.
- Burst crossing the top (idx + burst_size ≥ depth): behaviour set by the macro (see Configuration).
- Read: RD_WAIT counts READ_LATENCY − 1, then RD_DATA drives burst_size + 1 consecutive beats with idx incrementing, then RD_END drives sb_end_transaction_o for one cycle, then IDLE.
- Write: WR_DATA commits sb_address_data_i under the byte enables on each cycle where sb_data_valid_i = 1 and sb_busy_o = 0, then increments idx.
  - A valid beat arriving after the beat count is exhausted → ERR; that beat is not written.
  - sb_end_transaction_i → IDLE. Fewer beats than announced is legal.
- ERR: sb_error_o = 1 for exactly one cycle, then IDLE. The slave does not assert end-transaction in this path.
- Aborts:
  - sb_error_i in any non-IDLE state → IDLE next cycle; a beat in that cycle is not written.
  - sb_end_transaction_i during a read → IDLE, and beat output stops.
- sb_begin_transaction_i outside IDLE is ignored.
- Memory contents are not reset.

## Timing
- Reset: FSM = IDLE; every output = 0 asynchronously on assertion, including mid-transaction. There is no pending state after deassertion.
- Begin sampled at edge T:
  - First read beat is visible in cycle T+READ_LATENCY.
  - Beat k is visible in cycle T+READ_LATENCY+k.
  - sb_end_transaction_o is visible in cycle T+READ_LATENCY+burst_size+1.
- Write busy: sb_busy_o = 1 in cycles T+1..T+WRITE_WAIT, 0 otherwise. The master holds the beat while busy.
- Write-to-read: data written in cycle C is returned by a read whose begin is at C+1 or later.
- Error pulse for a top-crossing burst (macro absent): cycle T+1.
- Throughput: one beat per cycle in both directions, no inter-beat bubbles.

## Configuration
- SB_MEM_SLAVE_WRAP_EN defined: bursts crossing the top wrap idx modulo depth (index 2^ADDR_BITS−1 → 0); no error.
- SB_MEM_SLAVE_WRAP_EN absent: a read or write burst whose last index is ≥ depth → ERR at T+1. No data is driven and nothing is written.

## Test plan
- Single write/read, BASE_ADDR = 0, ADDR_BITS = 12, READ_LATENCY = 2:
  - Stimulus: write 32'hDEAD_BEEF to 32'h0000_1000, then read 1 word from 32'h0000_1000.
  - Required: data_valid_o in T+2 with 32'hDEAD_BEEF; end_transaction_o in T+3; address_data_o = 0 in every other cycle.
- Byte enables:
  - Stimulus: over 32'hDEAD_BEEF, write 32'h1122_3344 with byte_enables = 4'b0101; read back.
  - Required: 32'hDE22_BE44.
- Burst read:
  - Stimulus: preload words 0..3 with 1, 2, 3, 4; burst_size = 3 at address 0.
  - Required: beats 1, 2, 3, 4 in T+2..T+5; end_transaction_o in T+6.
- Window miss:
  - Stimulus: begin at 32'h8000_0000.
  - Required: all outputs stay 0 for 20 cycles; FSM stays IDLE.
- Top crossing:
  - Stimulus: read at word 4094, burst_size = 3.
  - Required without the macro: sb_error_o = 1 only in T+1 and no beats.
  - Required with the macro: beats from words 4094, 4095, 0, 1.
- Back-pressure and reset:
  - Stimulus: WRITE_WAIT = 3; write 2 beats.
  - Required: sb_busy_o high in T+1..T+3; first beat committed in T+4.
  - Stimulus: assert sb_reset_n_i = 0 mid-burst.
  - Required: all outputs 0 immediately; a following begin is serviced normally.
